// File: rtl/clk_gen_pkg.sv
// Shared defaults and helpers for the clock-enable generator.
// div_eff() maps a zero divisor onto 1 so every channel always has a legal period.
package clk_gen_pkg;
  localparam int DIV_W_DEF   = 8;
  localparam int HOLDOFF_DEF = 16;
  // Widest divisor the helper handles; callers zero-extend into it.
  localparam int DIV_MAX_W   = 32;

  function automatic logic [DIV_MAX_W-1:0] div_eff(input logic [DIV_MAX_W-1:0] n);
    return (n == '0) ? DIV_MAX_W'(1) : n;
  endfunction
endpackage

// File: rtl/clk_enable_channel.sv
// One divider channel: counts enabled cycles and emits a one-cycle strobe
// plus a 50% square wave every div_act counted cycles.
module clk_enable_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             align,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             stb,
  output logic             sq
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_next;
  logic             terminal;

  assign div_next = DIV_W'(div_eff(DIV_MAX_W'(div)));
  // div_act is never 0, so the subtraction cannot underflow while counting.
  assign terminal = (cnt == div_act - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= DIV_W'(1);
      stb     <= 1'b0;
      sq      <= 1'b0;
    end else if (!ready || align) begin
      cnt     <= '0;
      div_act <= div_next;
      stb     <= 1'b0;
      sq      <= 1'b0;
    end else if (!run) begin
      stb <= 1'b0;
    end else if (terminal) begin
      // A new divisor is only picked up here, so periods are never cut short.
      cnt     <= '0;
      div_act <= div_next;
      stb     <= 1'b1;
      sq      <= ~sq;
    end else begin
      cnt <= cnt + DIV_W'(1);
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Board-level reset release and multi-channel clock-enable generator.
// RESET asserts RST_OUT asynchronously; release is synchronised and held off.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       RUN,
  input  logic                    ALIGN,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic                    RST_OUT,
  output logic                    READY,
  output logic [NUM_CH-1:0]       STB,
  output logic [NUM_CH-1:0]       SQ
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [1:0]    sync;
  logic [HW-1:0] hold_cnt;
  logic          ready;

  // sync[1] goes low on the 2nd edge after release; the holdoff then runs
  // HOLDOFF more edges, so ready rises on edge 2+HOLDOFF.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync     <= 2'b11;
      hold_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      sync <= {sync[0], 1'b0};
      if (!sync[1] && !ready) begin
        if (hold_cnt == HW'(HOLDOFF - 1)) begin
          ready <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

  // Both outputs come straight from one flop, so they cannot glitch.
  assign READY   = ready;
  assign RST_OUT = ~ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_enable_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk  (CLK),
      .rst  (RESET),
      .ready(ready),
      .align(ALIGN),
      .run  (RUN[i]),
      .div  (DIV[i*DIV_W +: DIV_W]),
      .stb  (STB[i]),
      .sq   (SQ[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: hand sequences, a vector table and
// randomized traffic compared against a counted-cycles reference model.
module tb_clk_enable_gen;
  localparam int NUM_CH  = 2;
  localparam int DIV_W   = 8;
  localparam int HOLDOFF = 4;

  logic                    CLK;
  logic                    RESET;
  logic [NUM_CH-1:0]       RUN;
  logic                    ALIGN;
  logic [NUM_CH*DIV_W-1:0] DIV;
  logic                    RST_OUT;
  logic                    READY;
  logic [NUM_CH-1:0]       STB;
  logic [NUM_CH-1:0]       SQ;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since release, counted cycles in the
  // current period and the period length latched at period start.
  int              m_edges;
  bit              m_ready;
  int              m_el  [NUM_CH];
  int              m_per [NUM_CH];
  bit [NUM_CH-1:0] m_stb;
  bit [NUM_CH-1:0] m_sq;

  typedef struct {
    logic [1:0] run;
    logic       align;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] stb;
    logic [1:0] sq;
  } vec_t;

  vec_t tbl [14];

  clk_enable_gen #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .RUN    (RUN),
    .ALIGN  (ALIGN),
    .DIV    (DIV),
    .RST_OUT(RST_OUT),
    .READY  (READY),
    .STB    (STB),
    .SQ     (SQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_edges = 0;
    m_ready = 1'b0;
    m_stb   = '0;
    m_sq    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_el[i]  = 0;
      m_per[i] = 1;
    end
  endfunction

  function automatic void model_edge();
    bit rdy_prev;
    int neff;
    rdy_prev = m_ready;
    if (RESET) begin
      model_reset();
      return;
    end
    if (m_edges < 1000) m_edges++;
    m_ready = (m_edges >= 2 + HOLDOFF);
    for (int i = 0; i < NUM_CH; i++) begin
      neff = int'(DIV[i*DIV_W +: DIV_W]);
      if (neff == 0) neff = 1;
      if (!rdy_prev || ALIGN) begin
        m_el[i]  = 0;
        m_per[i] = neff;
        m_stb[i] = 1'b0;
        m_sq[i]  = 1'b0;
      end else if (!RUN[i]) begin
        m_stb[i] = 1'b0;
      end else begin
        m_el[i]++;
        if (m_el[i] == m_per[i]) begin
          m_el[i]  = 0;
          m_per[i] = neff;
          m_stb[i] = 1'b1;
          m_sq[i]  = ~m_sq[i];
        end else begin
          m_stb[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, 32'(READY), 32'(m_ready));
    chk({tag, "_rst_out"}, 32'(RST_OUT), 32'(!m_ready));
    chk({tag, "_stb"}, 32'(STB), 32'(m_stb));
    chk({tag, "_sq"}, 32'(SQ), 32'(m_sq));
  endtask

  initial begin
    tbl[0]  = '{2'b11, 1'b1, 8'd2, 8'd3, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 1'b0, 8'd2, 8'd3, 2'b00, 2'b00};
    tbl[2]  = '{2'b11, 1'b0, 8'd2, 8'd3, 2'b01, 2'b01};
    tbl[3]  = '{2'b11, 1'b0, 8'd2, 8'd3, 2'b10, 2'b11};
    tbl[4]  = '{2'b11, 1'b0, 8'd2, 8'd3, 2'b01, 2'b10};
    tbl[5]  = '{2'b10, 1'b0, 8'd2, 8'd3, 2'b00, 2'b10};
    tbl[6]  = '{2'b11, 1'b0, 8'd2, 8'd3, 2'b10, 2'b00};
    tbl[7]  = '{2'b11, 1'b0, 8'd0, 8'd1, 2'b01, 2'b01};
    tbl[8]  = '{2'b11, 1'b0, 8'd0, 8'd1, 2'b01, 2'b00};
    tbl[9]  = '{2'b11, 1'b0, 8'd0, 8'd1, 2'b11, 2'b11};
    tbl[10] = '{2'b11, 1'b0, 8'd0, 8'd1, 2'b11, 2'b00};
    tbl[11] = '{2'b11, 1'b0, 8'd0, 8'd1, 2'b11, 2'b11};
    tbl[12] = '{2'b00, 1'b0, 8'd0, 8'd1, 2'b00, 2'b11};
    tbl[13] = '{2'b11, 1'b1, 8'd0, 8'd1, 2'b00, 2'b00};

    model_reset();
    RESET = 1'b1;
    RUN   = '0;
    ALIGN = 1'b0;
    DIV   = '0;
    step();
    step();
    chk("reset_rst_out", 32'(RST_OUT), 32'd1);
    chk("reset_ready", 32'(READY), 32'd0);
    chk("reset_stb", 32'(STB), 32'd0);
    chk("reset_sq", 32'(SQ), 32'd0);

    // Reset release: READY rises on edge 2+HOLDOFF.
    RUN   = 2'b11;
    DIV   = {8'd6, 8'd4};
    RESET = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("release_ready", 32'(READY), 32'(e >= 6));
      chk("release_rst_out", 32'(RST_OUT), 32'(e < 6));
      chk("release_stb", 32'(STB), 32'd0);
      chk("release_sq", 32'(SQ), 32'd0);
    end

    // Divide by 4: strobe every 4th cycle, square period 8.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("div4_stb0", 32'(STB[0]), 32'(k % 4 == 0));
      chk("div4_sq0", 32'(SQ[0]), 32'((k / 4) % 2));
    end

    // Change the divisor mid-period: current period finishes at 4.
    step();
    chk("divchg_stb0_k17", 32'(STB[0]), 32'd0);
    DIV[7:0] = 8'd10;
    for (int k = 18; k <= 40; k++) begin
      step();
      chk("divchg_stb0", 32'(STB[0]), 32'(k == 20 || k == 30 || k == 40));
    end

    for (int v = 0; v < 14; v++) begin
      RUN   = tbl[v].run;
      ALIGN = tbl[v].align;
      DIV   = {tbl[v].d1, tbl[v].d0};
      step();
      chk($sformatf("tbl%0d_stb", v), 32'(STB), 32'(tbl[v].stb));
      chk($sformatf("tbl%0d_sq", v), 32'(SQ), 32'(tbl[v].sq));
    end

    // ALIGN restarts both channels in phase; 3 and 5 meet at 15.
    DIV   = {8'd5, 8'd3};
    RUN   = 2'b11;
    ALIGN = 1'b1;
    step();
    chk("align_sq", 32'(SQ), 32'd0);
    chk("align_stb", 32'(STB), 32'd0);
    ALIGN = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      step();
      chk("align_stb0", 32'(STB[0]), 32'(j % 3 == 0));
      chk("align_stb1", 32'(STB[1]), 32'(j % 5 == 0));
    end
    chk("align_sq_j15", 32'(SQ), 32'd3);

    // RUN0 low for 3 cycles delays the strobe by exactly 3.
    DIV[7:0] = 8'd4;
    ALIGN    = 1'b1;
    step();
    ALIGN = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      RUN[0] = !(j >= 3 && j <= 5);
      step();
      chk("freeze_stb0", 32'(STB[0]), 32'(j == 7));
      chk("freeze_sq0", 32'(SQ[0]), 32'(j >= 7));
    end

    // Asynchronous reset between clock edges.
    RESET = 1'b1;
    #2;
    model_reset();
    chk("arst_ready", 32'(READY), 32'd0);
    chk("arst_rst_out", 32'(RST_OUT), 32'd1);
    chk("arst_stb", 32'(STB), 32'd0);
    chk("arst_sq", 32'(SQ), 32'd0);
    step();
    step();
    RESET = 1'b0;

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        RESET = 1'b1;
        #1;
        model_reset();
        check_model("rnd_arst");
        step();
        RESET = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) RUN[i] = ($urandom_range(0, 9) != 0);
      ALIGN = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 3) == 0) DIV[i*DIV_W +: DIV_W] = 8'($urandom_range(0, 40));
          else                           DIV[i*DIV_W +: DIV_W] = 8'($urandom_range(0, 6));
        end
      end
      step();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
